dmem_responder: RTL and testbench

Data-memory responder for the `RISC_V_pipeline` MEM stage. It accepts one load or store request at a time over a valid/ready handshake and inserts a configurable number of wait states. It performs byte, half and word lane steering with sign or zero extension, and returns a single-cycle response pulse carrying the read data and an error flag. It is the target end of the pipeline's data-memory interface and lets the pipeline's stall logic be exercised against non-zero memory latency.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_lane_align.sv | 60 ++++++
 rtl/dmem_responder.sv | 126 ++++++++++++
 tb/tb_dmem_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states
// and the wait-state limit.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MAX_WAIT_CYCLES = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for loads and stores. With DMEM_MISALIGN_TRAP_EN defined,
// unaligned half/word accesses are flagged; otherwise low address bits are forced aligned.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_rep_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [1:0]  off;
  logic [31:0] shifted;
  logic        sext;

  always_comb begin
    off          = addr_lo_i;
    misaligned_o = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    misaligned_o = ((size_i == SZ_HALF) && addr_lo_i[0]) ||
                   ((size_i == SZ_WORD) && (addr_lo_i != 2'b00));
`else
    if (size_i == SZ_HALF) off = {addr_lo_i[1], 1'b0};
    if (size_i == SZ_WORD) off = 2'b00;
`endif
  end

  assign shifted = rword_i >> {off, 3'b000};
  assign sext    = ~unsigned_i;

  always_comb begin
    be_o        = 4'b0000;
    wdata_rep_o = 32'h0;
    rdata_o     = 32'h0;
    case (size_i)
      SZ_BYTE: begin
        be_o        = 4'b0001 << off;
        wdata_rep_o = {4{wdata_i[7:0]}};
        rdata_o     = {{24{shifted[7] & sext}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o        = 4'b0011 << off;
        wdata_rep_o = {2{wdata_i[15:0]}};
        rdata_o     = {{16{shifted[15] & sext}}, shifted[15:0]};
      end
      SZ_WORD: begin
        be_o        = 4'b1111;
        wdata_rep_o = wdata_i;
        rdata_o     = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline MEM stage: one request at a time,
// WAIT_CYCLES wait states, single-cycle response. Option: DMEM_MISALIGN_TRAP_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW       = $clog2(DEPTH);
  localparam int WAIT_EFF = (WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES;

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and the response has no backpressure.
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        capture;

  logic [31:0] mem_q [DEPTH];

  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdata_rep, rdata_ext;
  logic          misaligned, range_err, err;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    capture    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture = 1'b1;
          if (WAIT_EFF == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_EFF - 1);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= SZ_BYTE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
      end
    end
  end

  assign idx       = addr_q[AW+1:2];
  assign range_err = |addr_q[31:AW+2];

  dmem_lane_align u_align (
    .size_i      (size_q),
    .addr_lo_i   (addr_q[1:0]),
    .unsigned_i  (uns_q),
    .wdata_i     (wdata_q),
    .rword_i     (mem_q[idx]),
    .be_o        (be),
    .wdata_rep_o (wdata_rep),
    .rdata_o     (rdata_ext),
    .misaligned_o(misaligned)
  );

  assign err        = range_err | (size_q == 2'b11) | misaligned;
  assign resp_err   = resp_valid & err;
  assign resp_rdata = (resp_valid && !we_q && !err) ? rdata_ext : 32'h0;
  assign dbg_state  = state_q;

  // Memory is deliberately unreset; the write lands on the edge that ends RESP,
  // so an async reset during WAIT/RESP leaves it untouched.
  always_ff @(posedge clk) begin
    if (resp_valid && we_q && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with WAIT_CYCLES = 2 and DEPTH = 1024.
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .dbg_state   (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction: handshake, wait for the response pulse, check timing.
  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_size = size; req_unsigned = uns; req_wdata = wdata;
    check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 40) begin
      check({tag, ".ready_busy"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".resp_seen"}, 32'(resp_valid), 32'd1);
    check({tag, ".latency"}, 32'(cyc), 32'(W + 1));
    check({tag, ".ready_resp"}, 32'(req_ready), 32'd0);
    rdata = resp_rdata;
    err   = resp_err;
    @(posedge clk); #1;
    check({tag, ".pulse_end"}, 32'(resp_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("rst.ready", 32'(req_ready), 32'd1);
      check("rst.valid", 32'(resp_valid), 32'd0);
      check("rst.err", 32'(resp_err), 32'd0);
      check("rst.rdata", resp_rdata, 32'h0);
      check("rst.state", 32'(dbg_state), 32'd0);
    end

    xact("sw10", 1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF, rd, er);
    check("sw10.err", 32'(er), 32'd0);
    check("sw10.rdata", rd, 32'h0);
    xact("lw10", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er);
    check("lw10.err", 32'(er), 32'd0);
    check("lw10.rdata", rd, 32'hDEADBEEF);

    xact("sb13", 1'b1, 32'h13, 2'b00, 1'b0, 32'h00000080, rd, er);
    check("sb13.err", 32'(er), 32'd0);
    xact("lb13", 1'b0, 32'h13, 2'b00, 1'b0, 32'h0, rd, er);
    check("lb13.rdata", rd, 32'hFFFFFF80);
    xact("lbu13", 1'b0, 32'h13, 2'b00, 1'b1, 32'h0, rd, er);
    check("lbu13.rdata", rd, 32'h00000080);
    xact("lw10b", 1'b0, 32'h10, 2'b10, 1'b1, 32'h0, rd, er);
    check("lw10b.rdata", rd, 32'h80ADBEEF);
    xact("lh12", 1'b0, 32'h12, 2'b01, 1'b0, 32'h0, rd, er);
    check("lh12.rdata", rd, 32'hFFFF80AD);
    xact("lhu12", 1'b0, 32'h12, 2'b01, 1'b1, 32'h0, rd, er);
    check("lhu12.rdata", rd, 32'h000080AD);
    xact("lb11", 1'b0, 32'h11, 2'b00, 1'b0, 32'h0, rd, er);
    check("lb11.rdata", rd, 32'hFFFFFFBE);

    xact("lw_oor", 1'b0, 32'h00001000, 2'b10, 1'b0, 32'h0, rd, er);
    check("lw_oor.err", 32'(er), 32'd1);
    check("lw_oor.rdata", rd, 32'h0);
    xact("ls11", 1'b0, 32'h10, 2'b11, 1'b0, 32'h0, rd, er);
    check("ls11.err", 32'(er), 32'd1);
    check("ls11.rdata", rd, 32'h0);
    xact("sw_oor", 1'b1, 32'h00001010, 2'b10, 1'b0, 32'h55555555, rd, er);
    check("sw_oor.err", 32'(er), 32'd1);
    xact("lw10c", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er);
    check("lw10c.rdata", rd, 32'h80ADBEEF);

    xact("sh11", 1'b1, 32'h11, 2'b01, 1'b0, 32'h00001234, rd, er);
    xact("lw10d", 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    check("lw10d.rdata", rd, 32'h80ADBEEF);
    xact("lw11m", 1'b0, 32'h11, 2'b10, 1'b0, 32'h0, rd, er);
    check("lw11m.err", 32'(er), 32'd1);
    check("lw11m.rdata", rd, 32'h0);
`else
    check("lw10d.rdata", rd, 32'h80AD1234);
    xact("lw11m", 1'b0, 32'h11, 2'b10, 1'b0, 32'h0, rd, er);
    check("lw11m.err", 32'(er), 32'd0);
    check("lw11m.rdata", rd, 32'h80AD1234);
`endif

    xact("sw20", 1'b1, 32'h20, 2'b10, 1'b0, 32'h11111111, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20;
    req_size = 2'b10; req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid.state_wait", 32'(dbg_state), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid.state_idle", 32'(dbg_state), 32'd0);
    check("mid.ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("mid.no_resp", 32'(resp_valid), 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mid.no_resp_after", 32'(resp_valid), 32'd0);
    end
    xact("lw20", 1'b0, 32'h20, 2'b10, 1'b0, 32'h0, rd, er);
    check("lw20.rdata", rd, 32'h11111111);
    check("lw20.err", 32'(er), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
